// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD rectangle-fill arbiter.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned COLOR_W = 16;
  localparam int unsigned RECT_W  = 4 * COORD_W + COLOR_W;
  localparam int unsigned HDR_LEN = 11;

  // One requester's slice of req_data, x0 in the MSBs and color in the LSBs.
  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COLOR_W-1:0] color;
  } rect_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HDR,
    ST_PIX_HI,
    ST_PIX_LO,
    ST_FIN
  } state_e;

endpackage

// File: rtl/lcd_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after the pointer.
module lcd_rr_arb #(
  parameter int unsigned N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [1:0]       gnt_idx_c_o,
  output logic             any_c_o
);

  localparam logic [2:0] NR = 3'(N_REQ);

  logic [3:0] req4;
  logic [2:0] sum;
  logic [1:0] idx;

  assign req4 = 4'(req_i);

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    gnt_idx_c_o = '0;
    any_c_o     = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = 3'(ptr_i) + 3'(k);
      idx = (sum >= NR) ? 2'(sum - NR) : 2'(sum);
      if (req4[idx]) begin
        gnt_idx_c_o = idx;
        any_c_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_rect_arbiter.sv
// Round-robin arbiter that turns granted rectangle fills into ST7789 window
// draws (CASET, RASET, RAMWR, solid pixels) for a downstream byte serializer.
module lcd_rect_arbiter
  import lcd_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned LCD_W = 240,
  parameter int unsigned LCD_H = 135,
  parameter int unsigned X_OFS = 40,
  parameter int unsigned Y_OFS = 53
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    init_done,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*RECT_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_byte,
  output logic                    tx_dc,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              done_id,
  output logic                    err
);

  localparam logic [8:0] LCD_W9 = 9'(LCD_W);
  localparam logic [8:0] LCD_H9 = 9'(LCD_H);
  localparam logic [2:0] NR3    = 3'(N_REQ);

  state_e           state_q, state_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       gnt_q, gnt_d;
  rect_t            rect_q, rect_d;
  logic [15:0]      pix_cnt_q, pix_cnt_d;
  logic [3:0]       hdr_idx_q, hdr_idx_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             tx_dc_q, tx_dc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       done_id_q, done_id_d;
  logic             err_q, err_d;

  logic [1:0]  gnt_idx_c;
  logic        any_c;
  rect_t       req_rect [4];
  logic [15:0] xs_c, xe_c, ys_c, ye_c;
  logic [7:0]  hdr_byte_c;
  logic        hdr_dc_c;
  logic        reject_c;
  logic [8:0]  w_c, h_c;
  logic [2:0]  gnt_inc_c;

  lcd_rr_arb #(.N_REQ(N_REQ)) u_rr_arb (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .gnt_idx_c_o (gnt_idx_c),
    .any_c_o     (any_c)
  );

  // Unpack requesters into a power-of-two array so a 2-bit grant indexes it cleanly.
  for (genvar i = 0; i < 4; i++) begin : g_rect
    if (i < N_REQ) begin : g_used
      assign req_rect[i] = rect_t'(req_data[i*RECT_W +: RECT_W]);
    end else begin : g_pad
      assign req_rect[i] = '0;
    end
  end

  assign xs_c      = 16'(rect_q.x0) + 16'(X_OFS);
  assign xe_c      = 16'(rect_q.x1) + 16'(X_OFS);
  assign ys_c      = 16'(rect_q.y0) + 16'(Y_OFS);
  assign ye_c      = 16'(rect_q.y1) + 16'(Y_OFS);
  assign w_c       = 9'(rect_q.x1) - 9'(rect_q.x0) + 9'd1;
  assign h_c       = 9'(rect_q.y1) - 9'(rect_q.y0) + 9'd1;
  assign gnt_inc_c = 3'(gnt_q) + 3'd1;
  assign reject_c  = (rect_q.x0 > rect_q.x1) || (rect_q.y0 > rect_q.y1) ||
                     ({1'b0, rect_q.x1} >= LCD_W9) || ({1'b0, rect_q.y1} >= LCD_H9);

  // Window header byte selected by hdr_idx_q.
  always_comb begin
    hdr_byte_c = 8'h00;
    hdr_dc_c   = 1'b1;
    case (hdr_idx_q)
      4'd0:    begin hdr_byte_c = CMD_CASET; hdr_dc_c = 1'b0; end
      4'd1:    hdr_byte_c = xs_c[15:8];
      4'd2:    hdr_byte_c = xs_c[7:0];
      4'd3:    hdr_byte_c = xe_c[15:8];
      4'd4:    hdr_byte_c = xe_c[7:0];
      4'd5:    begin hdr_byte_c = CMD_RASET; hdr_dc_c = 1'b0; end
      4'd6:    hdr_byte_c = ys_c[15:8];
      4'd7:    hdr_byte_c = ys_c[7:0];
      4'd8:    hdr_byte_c = ye_c[15:8];
      4'd9:    hdr_byte_c = ye_c[7:0];
      4'd10:   begin hdr_byte_c = CMD_RAMWR; hdr_dc_c = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    rect_d      = rect_q;
    pix_cnt_d   = pix_cnt_q;
    hdr_idx_d   = hdr_idx_q;
    req_ready_d = '0;
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    tx_dc_d     = tx_dc_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_done && any_c) begin
          gnt_d       = gnt_idx_c;
          rect_d      = req_rect[gnt_idx_c];
          req_ready_d = N_REQ'(4'b0001 << gnt_idx_c);
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject_c) begin
          done_d    = 1'b1;
          err_d     = 1'b1;
          done_id_d = gnt_q;
          state_d   = ST_IDLE;
        end else begin
          pix_cnt_d = 16'(w_c) * 16'(h_c);
          hdr_idx_d = '0;
          state_d   = ST_HDR;
        end
      end
      // The presented byte is replaced when the register is empty or being accepted.
      ST_HDR: begin
        if (!tx_valid_q || tx_ready) begin
          tx_valid_d = 1'b1;
          if (hdr_idx_q == 4'(HDR_LEN)) begin
            tx_byte_d = rect_q.color[15:8];
            tx_dc_d   = 1'b1;
            state_d   = ST_PIX_HI;
          end else begin
            tx_byte_d = hdr_byte_c;
            tx_dc_d   = hdr_dc_c;
            hdr_idx_d = hdr_idx_q + 4'd1;
          end
        end
      end
      ST_PIX_HI: begin
        if (tx_valid_q && tx_ready) begin
          tx_byte_d = rect_q.color[7:0];
          state_d   = ST_PIX_LO;
        end
      end
      ST_PIX_LO: begin
        if (tx_valid_q && tx_ready) begin
          pix_cnt_d = pix_cnt_q - 16'd1;
          if (pix_cnt_q == 16'd1) begin
            tx_valid_d = 1'b0;
            state_d    = ST_FIN;
          end else begin
            tx_byte_d = rect_q.color[15:8];
            state_d   = ST_PIX_HI;
          end
        end
      end
      ST_FIN: begin
        done_d    = 1'b1;
        done_id_d = gnt_q;
        rr_ptr_d  = (gnt_inc_c >= NR3) ? 2'd0 : 2'(gnt_inc_c);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      rect_q      <= '0;
      pix_cnt_q   <= '0;
      hdr_idx_q   <= '0;
      req_ready_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
      tx_dc_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rect_q      <= rect_d;
      pix_cnt_q   <= pix_cnt_d;
      hdr_idx_q   <= hdr_idx_d;
      req_ready_q <= req_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      tx_dc_q     <= tx_dc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;
  assign tx_dc     = tx_dc_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_rect_arbiter.sv
// Bench for lcd_rect_arbiter: directed draws plus randomized rectangles against a byte-list model.
module tb_lcd_rect_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        init_done;
  logic [1:0]  req_valid;
  logic [95:0] req_data;
  logic [1:0]  req_ready;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        tx_dc;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int rr_ptr_m = 0;
  bit ok_dummy;

  lcd_rect_arbiter #(.N_REQ(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_byte   (tx_byte),
    .tx_dc     (tx_dc),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v,
                     output bit ok);
    checks++;
    ok = (obs === exp_v);
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Issue one rectangle on requester r and check the whole resulting byte stream.
  // bp_mode: 0 always ready, 1 random ready, 2 five-cycle stall on byte 16 (low byte of pixel 3).
  task automatic do_rect(input int r, input int x0, input int y0, input int x1, input int y1,
                         input int color, input int bp_mode, input bit drop_init);
    logic [8:0] exp_q[$];
    logic [8:0] cur, prev, e;
    bit rej, bad, seen_done, prev_stall, ok;
    int n, nacc, stall, bound, gcyc;
    int xs, xe, ys, ye;

    rej = (x0 > x1) || (y0 > y1) || (x1 >= 240) || (y1 >= 135);
    if (!rej) begin
      xs = x0 + 40; xe = x1 + 40; ys = y0 + 53; ye = y1 + 53;
      exp_q.push_back({1'b0, 8'h2A});
      exp_q.push_back({1'b1, 8'(xs >> 8)}); exp_q.push_back({1'b1, 8'(xs)});
      exp_q.push_back({1'b1, 8'(xe >> 8)}); exp_q.push_back({1'b1, 8'(xe)});
      exp_q.push_back({1'b0, 8'h2B});
      exp_q.push_back({1'b1, 8'(ys >> 8)}); exp_q.push_back({1'b1, 8'(ys)});
      exp_q.push_back({1'b1, 8'(ye >> 8)}); exp_q.push_back({1'b1, 8'(ye)});
      exp_q.push_back({1'b0, 8'h2C});
      for (int p = 0; p < (x1 - x0 + 1) * (y1 - y0 + 1); p++) begin
        exp_q.push_back({1'b1, 8'(color >> 8)});
        exp_q.push_back({1'b1, 8'(color)});
      end
    end
    n = exp_q.size();
    bound = (bp_mode == 1) ? 8 * n + 60 : n + 60;

    req_data[r*48 +: 48] = {8'(x0), 8'(y0), 8'(x1), 8'(y1), 16'(color)};
    req_valid[r] = 1'b1;
    gcyc = 0;
    do begin
      @(negedge clk);
      gcyc++;
    end while (req_ready[r] !== 1'b1 && gcyc < 50);
    chk("grant", 32'(req_ready), 32'(1 << r), ok_dummy);
    chk("busy_at_grant", 32'(busy), 32'd1, ok_dummy);
    req_valid[r] = 1'b0;
    req_data[r*48 +: 48] = 48'({$urandom(), $urandom()});
    if (drop_init) init_done = 1'b0;

    bad = 1'b0; seen_done = 1'b0; prev_stall = 1'b0; nacc = 0; stall = 0; prev = '0;
    for (int cyc = 0; cyc < bound && !seen_done; cyc++) begin
      @(negedge clk);
      if (bp_mode == 1) tx_ready = ($urandom_range(0, 3) != 0);
      else if (bp_mode == 2 && tx_valid && nacc == 16 && stall < 5) begin
        tx_ready = 1'b0;
        stall++;
      end else tx_ready = 1'b1;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        chk("done_id", 32'(done_id), 32'(r), ok_dummy);
        chk("err", 32'(err), 32'(rej), ok_dummy);
        chk("bytes_left", 32'(exp_q.size()), 32'd0, ok_dummy);
        chk("bytes_sent", 32'(nacc), 32'(n), ok_dummy);
      end else if (tx_valid === 1'b1) begin
        cur = {tx_dc, tx_byte};
        if (prev_stall && !bad) begin
          chk("stall_hold", 32'(cur), 32'(prev), ok);
          if (!ok) bad = 1'b1;
        end
        if (tx_ready) begin
          if (!bad) begin
            if (exp_q.size() == 0) begin
              chk("extra_byte", 32'(cur), 32'h1FF, ok_dummy);
              bad = 1'b1;
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("byte%0d", nacc), 32'(cur), 32'(e), ok);
              if (!ok) bad = 1'b1;
              if (nacc == 0) chk("busy_drawing", 32'(busy), 32'd1, ok_dummy);
            end
          end
          nacc++;
        end
        prev_stall = !tx_ready;
        prev = cur;
      end else begin
        if (prev_stall && !bad) begin
          chk("valid_held", 32'(tx_valid), 32'd1, ok_dummy);
          bad = 1'b1;
        end
        prev_stall = 1'b0;
      end
    end
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1, ok_dummy);
    if (bp_mode == 2) chk("stall_cycles", 32'(stall), 32'd5, ok_dummy);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0, ok_dummy);
    chk("idle_busy", 32'(busy), 32'd0, ok_dummy);
    tx_ready = 1'b1;
    init_done = 1'b1;
    if (!rej) rr_ptr_m = (r + 1) % 2;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    req_valid = '0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rr_ptr_m = 0;
    @(negedge clk);
  endtask

  initial begin
    int x0, y0, x1, y1, w, h, t, gcount, gcyc, exp_r;
    logic [1:0] prev_rr;
    bit blocked, saw_done;

    resetn = 1'b0; init_done = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b0;
    #12;
    chk("reset_outputs_async",
        32'({req_ready, tx_valid, tx_byte, tx_dc, busy, done, done_id, err}), 32'd0, ok_dummy);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        32'({req_ready, tx_valid, tx_byte, tx_dc, busy, done, done_id, err}), 32'd0, ok_dummy);
    init_done = 1'b1;
    tx_ready = 1'b1;

    do_rect(0, 0, 0, 239, 134, 16'hF800, 0, 1'b0);
    do_rect(1, 10, 20, 10, 20, 16'h07E0, 1, 1'b1);
    do_rect(0, 0, 0, 240, 10, 16'h001F, 1, 1'b0);
    do_rect(0, 100, 50, 102, 51, 16'h1234, 1, 1'b0);
    do_rect(1, 0, 0, 3, 0, 16'hA55A, 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      x0 = $urandom_range(0, 239); w = $urandom_range(1, 10); x1 = x0 + w - 1;
      y0 = $urandom_range(0, 134); h = $urandom_range(1, 6);  y1 = y0 + h - 1;
      if ($urandom_range(0, 7) == 0) begin t = x0; x0 = x1; x1 = t; end
      if ($urandom_range(0, 7) == 0) begin t = y0; y0 = y1; y1 = t; end
      do_rect($urandom_range(0, 1), x0, y0, x1, y1, $urandom_range(0, 65535), 1, 1'b0);
    end

    // Both requesters held valid after reset: grants alternate from requester 0.
    apply_reset();
    req_data = {8'd1, 8'd1, 8'd1, 8'd1, 16'h1111, 8'd2, 8'd2, 8'd2, 8'd2, 16'h2222};
    req_valid = 2'b11;
    gcount = 0; prev_rr = '0;
    for (int cyc = 0; cyc < 400 && gcount < 4; cyc++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) begin
        chk("rr_one_cycle", 32'(prev_rr), 32'd0, ok_dummy);
        exp_r = rr_ptr_m;
        chk($sformatf("rr_grant%0d", gcount), 32'(req_ready), 32'(1 << exp_r), ok_dummy);
        rr_ptr_m = (exp_r + 1) % 2;
        gcount++;
        if (gcount == 4) req_valid = 2'b00;
      end
      prev_rr = req_ready;
    end
    chk("rr_grant_count", 32'(gcount), 32'd4, ok_dummy);
    gcyc = 0;
    do begin
      @(negedge clk);
      gcyc++;
    end while (busy !== 1'b0 && gcyc < 100);
    chk("rr_drain", 32'(busy), 32'd0, ok_dummy);

    // No grant without init_done; then reset in the middle of the header.
    apply_reset();
    init_done = 1'b0;
    req_data[47:0] = {8'd5, 8'd5, 8'd20, 8'd20, 16'hBEEF};
    req_valid[0] = 1'b1;
    blocked = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready !== 2'b00 || busy !== 1'b0 || tx_valid !== 1'b0) blocked = 1'b1;
    end
    chk("gate_no_grant", 32'(blocked), 32'd0, ok_dummy);
    init_done = 1'b1;
    gcyc = 0;
    do begin
      @(negedge clk);
      gcyc++;
    end while (req_ready[0] !== 1'b1 && gcyc < 20);
    chk("gate_grant", 32'(req_ready), 32'd1, ok_dummy);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("mid_hdr_valid", 32'(tx_valid), 32'd1, ok_dummy);
    #2 resetn = 1'b0;
    #1;
    chk("reset_drops_valid", 32'(tx_valid), 32'd0, ok_dummy);
    chk("reset_drops_busy", 32'(busy), 32'd0, ok_dummy);
    saw_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    resetn = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    chk("no_done_after_abort", 32'(saw_done), 32'd0, ok_dummy);
    do_rect(1, 3, 4, 5, 6, 16'h0F0F, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
